// File: rtl/posit_defines.sv
// Shared posit constants and types for the arithmetic units: format widths,
// the decoded-operand payload and the divider FSM state enum.
package posit_defines;

  localparam int unsigned NBITS     = 32;
  localparam int unsigned ES        = 2;
  localparam int unsigned FBITS     = NBITS - ES - 3;   // 27 stored fraction bits max
  localparam int unsigned FHBITS    = FBITS + 1;        // fraction with hidden bit
  localparam int unsigned SCALE_W   = 9;
  localparam int unsigned DIV_QBITS = 30;
  localparam int unsigned CNT_W     = 5;

  typedef logic [NBITS-1:0] posit_t;

  localparam posit_t POSIT_NAR = 32'h8000_0000;

  // Largest representable |scale|: all-ones / all-zeros regime with exponent 0.
  localparam logic signed [SCALE_W-1:0] SCALE_LIM = SCALE_W'(4 * (NBITS - 2));

  typedef struct packed {
    logic                      sign;
    logic signed [SCALE_W-1:0] scale;
    logic [FHBITS-1:0]         frac;   // hidden bit at MSB
    logic                      zero;
    logic                      inf;
  } posit_dec_t;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    ITERATE,
    PACK,
    DONE
  } div_state_t;

  // Special-case outcome of a division, {nar, zero}; NaR outranks zero.
  function automatic logic [1:0] div_special(input posit_dec_t a, input posit_dec_t b);
    logic nar;
    nar = a.inf | b.inf | b.zero;
    return {nar, !nar && a.zero};
  endfunction

endpackage

// File: rtl/posit_div_if.sv
// Request/response bundle of the posit divider.
//   start      : one-cycle request
//   in1, in2   : dividend / divisor posits
//   result     : quotient posit, inf/zero flags
//   done, busy : completion pulse and in-flight indicator
interface posit_div_if;
  import posit_defines::*;

  logic   start;
  posit_t in1;
  posit_t in2;
  posit_t result;
  logic   inf;
  logic   zero;
  logic   done;
  logic   busy;

  modport master (output start, in1, in2, input result, inf, zero, done, busy);
  modport slave  (input start, in1, in2, output result, inf, zero, done, busy);

endinterface

// File: rtl/posit_extract.sv
// Posit decoder: splits a 32-bit, es=2 posit into sign, scale, fraction with
// hidden bit, and zero/NaR flags.
//   x : posit to decode
//   d : decoded operand
module posit_extract
  import posit_defines::*;
(
  input  posit_t     x,
  output posit_dec_t d
);

  logic [NBITS-2:0]          body;
  logic [5:0]                run;
  logic [5:0]                sh;
  logic                      stop;
  logic [FBITS+ES-1:0]       rest;
  logic [ES-1:0]             exp_bits;
  logic signed [SCALE_W-1:0] run_s;
  logic signed [SCALE_W-1:0] k_s;

  always_comb begin
    body = x[NBITS-1] ? (~x[NBITS-2:0] + (NBITS-1)'(1)) : x[NBITS-2:0];
    // Regime run length: identical bits from the top of the magnitude.
    run  = '0;
    stop = 1'b0;
    for (int i = NBITS - 2; i >= 0; i--) begin
      if (!stop && (body[i] == body[NBITS-2])) run = run + 6'd1;
      else stop = 1'b1;
    end
    // Drop regime and its terminator, keep exponent + fraction left-aligned.
    sh       = run + 6'd1;
    rest     = (FBITS+ES)'((body << sh) >> ES);
    exp_bits = rest[FBITS+ES-1 -: ES];
    run_s    = SCALE_W'(run);
    k_s      = body[NBITS-2] ? (run_s - SCALE_W'(1)) : -run_s;

    d.sign  = x[NBITS-1];
    d.scale = (k_s <<< ES) + SCALE_W'(exp_bits);
    d.frac  = {1'b1, rest[FBITS-1:0]};
    d.zero  = (x == '0);
    d.inf   = (x == POSIT_NAR);
  end

endmodule

// File: rtl/posit_pack.sv
// Posit encoder shared by the arithmetic units: builds regime, exponent and
// fraction, rounds to nearest-even and saturates to maxpos/minpos.
//   sign   : result sign
//   scale  : 2^scale of the normalised value
//   frac   : bits below the hidden one; the LSB is the guard position
//   sticky : OR of everything below frac
//   posit  : encoded posit (never zero or NaR)
module posit_pack
  import posit_defines::*;
(
  input  logic                      sign,
  input  logic signed [SCALE_W-1:0] scale,
  input  logic [FHBITS-1:0]         frac,
  input  logic                      sticky,
  output posit_t                    posit
);

  localparam int unsigned RV_W  = NBITS;
  localparam int unsigned EXT_W = RV_W + ES + FHBITS + 2;

  logic signed [6:0] k;
  logic [5:0]        rlen;
  logic [RV_W-1:0]   rval;
  logic [EXT_W-1:0]  ext_raw;
  logic [EXT_W-1:0]  ext;
  logic [NBITS-2:0]  mag;
  logic [NBITS-2:0]  mag_c;
  logic              last;
  logic              guard;
  logic              st;

  always_comb begin
    k = 7'(scale >>> ES);
    // Regime: k+1 ones then a zero, or -k zeros then a one.
    if (!k[6]) begin
      rlen = 6'(k) + 6'd2;
      rval = ((RV_W'(1) << (6'(k) + 6'd1)) - RV_W'(1)) << 1;
    end else begin
      rlen = 6'(-k) + 6'd1;
      rval = RV_W'(1);
    end
    ext_raw = {rval, scale[ES-1:0], frac, 2'b00};
    ext     = ext_raw << (6'(RV_W) - rlen);

    mag   = ext[EXT_W-1 -: NBITS-1];
    last  = ext[EXT_W-NBITS+1];
    guard = ext[EXT_W-NBITS];
    st    = (|ext[EXT_W-NBITS-1:0]) | sticky;
    // A regime always holds a 0 and a 1 inside 31 bits, so rounding cannot wrap.
    mag_c = mag + (NBITS-1)'(guard & (last | st));

    if (scale > SCALE_LIM)       mag_c = '1;
    else if (scale < -SCALE_LIM) mag_c = (NBITS-1)'(1);

    posit = sign ? (~{1'b0, mag_c} + NBITS'(1)) : {1'b0, mag_c};
  end

endmodule

// File: rtl/posit_div.sv
// Multi-cycle posit (32,2) divider: decode, 30-step radix-2 restoring fraction
// divide, then round/pack. Fixed 33-cycle latency from start to done.
// Optional macro POSIT_DIV_EARLY_EXIT_EN: NaR/zero operands skip the divide
// and complete 2 cycles after start.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : start/in1/in2 request, result/inf/zero/done/busy response
module posit_div
  import posit_defines::*;
(
  input logic        clk,
  input logic        reset_n,
  posit_div_if.slave bus
);

  div_state_t                state;
  posit_t                    raw_a;
  posit_t                    raw_b;
  posit_dec_t                dec_a;
  posit_dec_t                dec_b;
  posit_dec_t                op_a;
  posit_dec_t                op_b;
  logic [CNT_W-1:0]          cnt;
  logic [FHBITS:0]           rem;
  logic [DIV_QBITS-1:0]      quo;
  posit_t                    result;
  logic                      inf;
  logic                      zero;
  logic                      done;
  logic                      busy;

  logic [FHBITS:0]           rem_cur;
  logic [FHBITS:0]           rem_sub;
  logic                      qbit;
  logic signed [SCALE_W-1:0] n_scale;
  logic [FHBITS-1:0]         n_frac;
  logic                      n_sticky;
  logic                      q_sign;
  posit_t                    packed_q;
  logic [1:0]                op_sp;

  posit_extract u_ext_a (.x(raw_a), .d(dec_a));
  posit_extract u_ext_b (.x(raw_b), .d(dec_b));

  // One restoring-division step; the first step starts from the dividend.
  always_comb begin
    rem_cur = (cnt == CNT_W'(DIV_QBITS - 1)) ? {1'b0, op_a.frac} : rem;
    qbit    = rem_cur >= {1'b0, op_b.frac};
    rem_sub = qbit ? (rem_cur - {1'b0, op_b.frac}) : rem_cur;
  end

  // Quotient lies in [0.5, 2); a missing integer bit means shift left, scale-1.
  always_comb begin
    n_scale = op_a.scale - op_b.scale;
    if (quo[DIV_QBITS-1]) begin
      n_frac   = quo[DIV_QBITS-2:1];
      n_sticky = quo[0] | (|rem);
    end else begin
      n_scale  = n_scale - SCALE_W'(1);
      n_frac   = quo[DIV_QBITS-3:0];
      n_sticky = |rem;
    end
    q_sign = op_a.sign ^ op_b.sign;
    op_sp  = div_special(op_a, op_b);
  end

  posit_pack u_pack (
    .sign   (q_sign),
    .scale  (n_scale),
    .frac   (n_frac),
    .sticky (n_sticky),
    .posit  (packed_q)
  );

`ifdef POSIT_DIV_EARLY_EXIT_EN
  logic [1:0] cap_sp;
  assign cap_sp = div_special(dec_a, dec_b);
`endif

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      raw_a  <= '0;
      raw_b  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      result <= '0;
      inf    <= 1'b0;
      zero   <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            raw_a <= bus.in1;
            raw_b <= bus.in2;
            busy  <= 1'b1;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          op_a  <= dec_a;
          op_b  <= dec_b;
          cnt   <= CNT_W'(DIV_QBITS - 1);
          rem   <= '0;
          quo   <= '0;
          state <= ITERATE;
`ifdef POSIT_DIV_EARLY_EXIT_EN
          if (|cap_sp) begin
            result <= cap_sp[1] ? POSIT_NAR : '0;
            inf    <= cap_sp[1];
            zero   <= cap_sp[0];
            done   <= 1'b1;
            state  <= DONE;
          end
`endif
        end
        ITERATE: begin
          quo <= {quo[DIV_QBITS-2:0], qbit};
          rem <= rem_sub << 1;
          if (cnt == '0) state <= PACK;
          else cnt <= cnt - CNT_W'(1);
        end
        PACK: begin
          result <= op_sp[1] ? POSIT_NAR : (op_sp[0] ? '0 : packed_q);
          inf    <= op_sp[1];
          zero   <= op_sp[0];
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result = result;
  assign bus.inf    = inf;
  assign bus.zero   = zero;
  assign bus.done   = done;
  assign bus.busy   = busy;

endmodule

// File: tb/tb_posit_div.sv
// Directed bench for posit_div: expected results are queued when a request is
// issued and compared when done fires, together with latency and flags.
module tb_posit_div;
  import posit_defines::*;

  logic clk = 1'b0;
  logic reset_n;

  posit_div_if bus ();

  posit_div dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

`ifdef POSIT_DIV_EARLY_EXIT_EN
  localparam int SPEC_LAT = 2;
`else
  localparam int SPEC_LAT = 33;
`endif
  localparam int FIX_LAT  = 33;
  localparam int MAX_WAIT = 80;

  typedef struct {
    posit_t res;
    logic   inf;
    logic   zero;
    int     lat;
    string  tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; issues one request and checks its completion.
  task automatic run_op(input posit_t a, input posit_t b, input posit_t res,
                        input logic ei, input logic ez, input int lat,
                        input string tag, input int second_at = 0);
    exp_t e;
    int   n;
    bus.in1   = a;
    bus.in2   = b;
    bus.start = 1'b1;
    sb.push_back('{res: res, inf: ei, zero: ez, lat: lat, tag: tag});
    @(negedge clk);
    bus.start = 1'b0;
    bus.in1   = $urandom;
    bus.in2   = $urandom;
    n = 1;
    check({tag, " busy"}, 32'(bus.busy), 32'd1);
    while (bus.done !== 1'b1 && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
      bus.start = (n == second_at);
      bus.in1   = $urandom;
      bus.in2   = $urandom;
    end
    e = sb.pop_front();
    check({e.tag, " done"}, 32'(bus.done), 32'd1);
    check({e.tag, " latency"}, 32'(n), 32'(e.lat));
    check({e.tag, " result"}, bus.result, e.res);
    check({e.tag, " inf"}, 32'(bus.inf), 32'(e.inf));
    check({e.tag, " zero"}, 32'(bus.zero), 32'(e.zero));
    if (second_at != 0) bus.start = 1'b1;   // start during DONE must be dropped
    @(negedge clk);
    bus.start = 1'b0;
    check({e.tag, " done pulse"}, 32'(bus.done), 32'd0);
    check({e.tag, " idle busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic seen;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    repeat (3) @(negedge clk);
    check("rst result", bus.result, 32'h0);
    check("rst inf", 32'(bus.inf), 32'd0);
    check("rst zero", 32'(bus.zero), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(32'h4800_0000, 32'h4000_0000, 32'h4800_0000, 1'b0, 1'b0, FIX_LAT, "2/1");
    run_op(32'h4000_0000, 32'h4C00_0000, 32'h32AA_AAAB, 1'b0, 1'b0, FIX_LAT, "1/3");
    run_op(32'h4000_0000, 32'hB800_0000, 32'hC800_0000, 1'b0, 1'b0, FIX_LAT, "1/-2");
    run_op(32'h4000_0000, 32'hB400_0000, 32'hCD55_5555, 1'b0, 1'b0, FIX_LAT, "1/-3");
    run_op(32'h5000_0000, 32'h4800_0000, 32'h4800_0000, 1'b0, 1'b0, FIX_LAT, "4/2");
    run_op(32'hB000_0000, 32'hB800_0000, 32'h4800_0000, 1'b0, 1'b0, FIX_LAT, "-4/-2");
    run_op(32'h4C00_0000, 32'h4800_0000, 32'h4400_0000, 1'b0, 1'b0, FIX_LAT, "3/2");
    run_op(32'h4000_0000, 32'h3800_0000, 32'h4800_0000, 1'b0, 1'b0, FIX_LAT, "1/0.5");
    run_op(32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, FIX_LAT, "minpos/maxpos");
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, FIX_LAT, "maxpos/minpos");
    run_op(32'h4000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, SPEC_LAT, "1/0");
    run_op(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b1, 1'b0, SPEC_LAT, "NaR/1");
    run_op(32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, SPEC_LAT, "0/0");
    run_op(32'h0000_0000, 32'h4800_0000, 32'h0000_0000, 1'b0, 1'b1, SPEC_LAT, "0/2");

    // Second start mid-divide plus a start in DONE: neither may launch work.
    run_op(32'h4000_0000, 32'h4C00_0000, 32'h32AA_AAAB, 1'b0, 1'b0, FIX_LAT, "restart", 10);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
    end
    check("no queued op", 32'(seen), 32'd0);

    // Reset in the middle of a divide aborts it without a done pulse.
    bus.in1   = 32'h4C00_0000;
    bus.in2   = 32'h4000_0000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort result", bus.result, 32'h0);
    @(negedge clk);
    check("abort done held", 32'(bus.done), 32'd0);
    reset_n = 1'b1;
    run_op(32'h4800_0000, 32'h4000_0000, 32'h4800_0000, 1'b0, 1'b0, FIX_LAT, "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/posit_div.md
POSIT_DIV -- requirements
Module: posit_div

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: one-cycle request; sampled only in IDLE.
REQ-004 SHALL have ports in1 and in2, input, 32 bits each: dividend and divisor posits (NBITS=32, ES=2).
REQ-005 SHALL have port result, output, 32 bits: quotient posit, held until the next done.
REQ-006 SHALL have ports inf and zero, output, 1 bit each: quotient is NaR / exact zero; valid when done is high and held afterwards.
REQ-007 SHALL have ports done, output, 1 bit (one-cycle pulse), and busy, output, 1 bit (high from the cycle after an accepted start through the done cycle).

Function
REQ-008 SHALL use FSM states IDLE, CAPTURE, ITERATE, PACK and DONE.
- IDLE -> CAPTURE on start.
- CAPTURE -> ITERATE.
- ITERATE -> PACK when the iteration counter reaches 0.
- PACK -> DONE.
- DONE -> IDLE.
REQ-009 SHALL, in CAPTURE, register both decoded operands, including sign, scale, fraction with the hidden bit (28 bits), zero and inf.
REQ-010 SHALL compute the fraction quotient with a radix-2 restoring divider, one quotient bit per cycle, for DIV_QBITS=30 cycles; the counter loads 29 and counts down to 0.
REQ-011 SHALL set the provisional scale to a.scale - b.scale (9-bit signed); if the dividend fraction is less than the divisor fraction, the scale is decremented by 1 and the quotient is normalised left by 1.
REQ-012 SHALL set sticky to the OR of the final remainder bits and any quotient bits below the guard bit.
REQ-013 SHALL, in PACK, encode the regime, the 2-bit exponent and the 27-bit fraction and then round to nearest, ties to even, from the last, guard and sticky bits.
REQ-014 SHALL clamp the result to maxpos (0x7FFFFFFF) or minpos (0x00000001) when scale > 120 or scale < -120; it SHALL never round to zero or to NaR.
REQ-015 SHALL set the sign to a.sign XOR b.sign; a negative result is the two's complement of the 31-bit magnitude.
REQ-016 SHALL apply these special cases, in priority order:
- in1 or in2 NaR: result 0x80000000, inf=1.
- in2 zero: result 0x80000000, inf=1.
- in1 zero: result 0x00000000, zero=1.
REQ-017 SHALL assert done exactly 33 cycles after the start cycle (fixed latency) when POSIT_DIV_EARLY_EXIT_EN is undefined.
REQ-018 SHALL ignore start while busy; no queueing takes place, and the operands in flight are unaffected by changes to in1 and in2.
REQ-019 SHALL allow a start asserted in the DONE cycle to be ignored, with a new start accepted from IDLE on the next cycle.

Reset
REQ-020 SHALL, while reset_n is low, force:
- the FSM to IDLE;
- result to 0x00000000;
- inf, zero, done and busy to 0;
- the counter, remainder and quotient registers to 0.
REQ-021 SHALL, on reset asserted mid-operation, abort the operation with no done pulse; after release the block accepts start on the first clk edge.

Configuration
REQ-022 SHALL, when POSIT_DIV_EARLY_EXIT_EN is defined, cause special-case operands (REQ-016) to go CAPTURE -> DONE, so that done appears 2 cycles after start; all other operands keep the REQ-017 latency.
REQ-023 SHALL, when POSIT_DIV_EARLY_EXIT_EN is undefined, run every operand, special cases included, through all states with the fixed latency, while still producing the REQ-016 outputs.

Structure
REQ-024 SHALL take NBITS, ES, FBITS, FHBITS and the value typedef from posit_defines; the DIV_QBITS constant and the FSM state enum SHALL be added to posit_defines.
REQ-025 SHALL reuse the existing posit_extract for operand decoding.
REQ-026 SHALL place regime/exponent/fraction rounding and packing in a sub-module named posit_pack (inputs: sign, scale, fraction, sticky; output: posit); posit_pack SHALL be shareable with the other arithmetic units.

Verification
REQ-027 SHALL verify 0x48000000 / 0x40000000 (2/1) -> result 0x48000000, done at cycle 33, inf=0, zero=0.
REQ-028 SHALL verify 0x40000000 / 0x4C000000 (1/3) -> result 0x32AAAAAB (round up on guard=1, sticky=1).
REQ-029 SHALL verify 0x40000000 / 0xB8000000 (1/-2) -> result 0xC8000000.
REQ-030 SHALL verify 0x40000000 / 0x00000000 -> result 0x80000000, inf=1; with POSIT_DIV_EARLY_EXIT_EN the done pulse comes at cycle 2, otherwise at cycle 33.
REQ-031 SHALL verify 0x00000001 / 0x7FFFFFFF -> 0x00000001, and 0x7FFFFFFF / 0x00000001 -> 0x7FFFFFFF (saturation, no zero or NaR).
REQ-032 SHALL verify a second start during ITERATE is ignored, and that reset_n pulsed low at cycle 10 gives busy=0, no done, and correct results for a new start afterwards.
